rob_multiport: RTL and testbench

- Parametrised reorder buffer; successor to the fixed 2-port, 4-entry commit buffer.
- Decode allocates in-order IDs.
- NUM_PORTS execution pipelines (ALU, MUL, future LSU) complete out of order.
- Results retire to the register file one per cycle, strictly in program order.
- Adds occupancy reporting, full-buffer flush on branch mispredict, and an arbitrary port count.

---
 rtl/rob_multiport.sv | 145 ++++++++++++++
 tb/tb_rob_multiport.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: in-order allocation, out-of-order writeback on
// NUM_PORTS ports, one in-order retirement per cycle, flush and occupancy.
module rob_multiport #(
    parameter int ID_SIZE          = 3,
    parameter int NUM_PORTS        = 2,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REG_SIZE         = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  alloc_req,
    output logic [ID_SIZE-1:0]                    alloc_id,
    output logic                                  alloc_stall,
    input  logic [NUM_PORTS-1:0]                  wb_req,
    input  logic [NUM_PORTS*ID_SIZE-1:0]          wb_id,
    input  logic [NUM_PORTS*REG_ADDRESS_SIZE-1:0] wb_address,
    input  logic [NUM_PORTS*REG_SIZE-1:0]         wb_data,
    input  logic [NUM_PORTS-1:0]                  wb_w,
    input  logic                                  flush,
    output logic                                  commit_valid,
    output logic [ID_SIZE-1:0]                    commit_id,
    output logic [REG_ADDRESS_SIZE-1:0]           commit_address,
    output logic [REG_SIZE-1:0]                   commit_data,
    output logic                                  commit_write,
    output logic [ID_SIZE:0]                      occupancy
);
    localparam int DEPTH = 1 << ID_SIZE;

    logic [DEPTH-1:0]                       valid_q, valid_d, done_q, done_d, w_q, w_d;
    logic [DEPTH-1:0][REG_ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][REG_SIZE-1:0]         data_q, data_d;
    logic [ID_SIZE-1:0]                     head_q, head_d, tail_q, tail_d;
    logic [ID_SIZE:0]                       count_q, count_d;
    logic                                   cvalid_q, cvalid_d, cwrite_q, cwrite_d;
    logic [ID_SIZE-1:0]                     cid_q, cid_d;
    logic [REG_ADDRESS_SIZE-1:0]            caddr_q, caddr_d;
    logic [REG_SIZE-1:0]                    cdata_q, cdata_d;

    logic               full, grant, commit;
    logic [ID_SIZE-1:0] wid;

    assign full        = (count_q == (ID_SIZE+1)'(DEPTH));
    assign grant       = alloc_req & ~full;
    assign commit      = valid_q[head_q] & done_q[head_q];
    assign alloc_id    = tail_q;
    assign alloc_stall = full;

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        w_d      = w_q;
        addr_d   = addr_q;
        data_d   = data_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + (ID_SIZE+1)'(grant) - (ID_SIZE+1)'(commit);
        cvalid_d = 1'b0;
        cwrite_d = 1'b0;
        cid_d    = cid_q;
        caddr_d  = caddr_q;
        cdata_d  = cdata_q;
        wid      = '0;

        // Walk ports high to low so the lowest index lands last and wins.
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            wid = wb_id[p*ID_SIZE +: ID_SIZE];
            if (wb_req[p] && valid_q[wid]) begin
                done_d[wid] = 1'b1;
                w_d[wid]    = wb_w[p];
                addr_d[wid] = wb_address[p*REG_ADDRESS_SIZE +: REG_ADDRESS_SIZE];
                data_d[wid] = wb_data[p*REG_SIZE +: REG_SIZE];
            end
        end

        if (commit) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + ID_SIZE'(1);
            cvalid_d        = 1'b1;
            cwrite_d        = w_q[head_q];
            cid_d           = head_q;
            caddr_d         = addr_q[head_q];
            cdata_d         = data_q[head_q];
        end

        if (grant) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + ID_SIZE'(1);
        end

        // Flush squashes everything still in flight, including this cycle's commit.
        if (flush) begin
            valid_d  = '0;
            done_d   = '0;
            head_d   = head_q;
            tail_d   = head_q;
            count_d  = '0;
            cvalid_d = 1'b0;
            cwrite_d = 1'b0;
            cid_d    = cid_q;
            caddr_d  = caddr_q;
            cdata_d  = cdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            done_q   <= '0;
            w_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cvalid_q <= 1'b0;
            cwrite_q <= 1'b0;
            cid_q    <= '0;
            caddr_q  <= '0;
            cdata_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            w_q      <= w_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cvalid_q <= cvalid_d;
            cwrite_q <= cwrite_d;
            cid_q    <= cid_d;
            caddr_q  <= caddr_d;
            cdata_q  <= cdata_d;
        end
    end

    assign commit_valid   = cvalid_q;
    assign commit_write   = cwrite_q;
    assign commit_id      = cid_q;
    assign commit_address = caddr_q;
    assign commit_data    = cdata_q;
    assign occupancy      = count_q;
endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: expected commits queued by the stimulus,
// popped and compared by an independent commit monitor.
module tb_rob_multiport;
    localparam int IS = 3;
    localparam int NP = 2;
    localparam int RA = 5;
    localparam int RS = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_req;
    logic [IS-1:0]     alloc_id;
    logic              alloc_stall;
    logic [NP-1:0]     wb_req;
    logic [NP*IS-1:0]  wb_id;
    logic [NP*RA-1:0]  wb_address;
    logic [NP*RS-1:0]  wb_data;
    logic [NP-1:0]     wb_w;
    logic              flush;
    logic              commit_valid;
    logic [IS-1:0]     commit_id;
    logic [RA-1:0]     commit_address;
    logic [RS-1:0]     commit_data;
    logic              commit_write;
    logic [IS:0]       occupancy;

    rob_multiport #(.ID_SIZE(IS), .NUM_PORTS(NP), .REG_ADDRESS_SIZE(RA), .REG_SIZE(RS)) dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_id(alloc_id),
        .alloc_stall(alloc_stall), .wb_req(wb_req), .wb_id(wb_id),
        .wb_address(wb_address), .wb_data(wb_data), .wb_w(wb_w), .flush(flush),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .commit_address(commit_address), .commit_data(commit_data),
        .commit_write(commit_write), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int addr; int data; int w; } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_req  = 1'b0;
        wb_req     = '0;
        wb_id      = '0;
        wb_address = '0;
        wb_data    = '0;
        wb_w       = '0;
        flush      = 1'b0;
    endtask

    task automatic set_wb(input int p, input int id, input int addr, input int data, input bit w);
        wb_req[p]             = 1'b1;
        wb_id[p*IS +: IS]     = IS'(id);
        wb_address[p*RA +: RA] = RA'(addr);
        wb_data[p*RS +: RS]   = RS'(data);
        wb_w[p]               = w;
    endtask

    task automatic push(input int id, input int addr, input int data, input int w);
        exp_t e;
        e.id = id; e.addr = addr; e.data = data; e.w = w;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (occupancy != 0 && k < 30) begin
            tick();
            k++;
        end
        @(negedge clk);
        #1;
        chk({name, "_occupancy"}, occupancy, 0);
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    // Commit monitor: every retirement must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && commit_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: got id %0d, expected no commit", commit_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_id", commit_id, e.id);
                chk("commit_address", commit_address, e.addr);
                chk("commit_data", commit_data, e.data);
                chk("commit_write", commit_write, e.w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_occupancy", occupancy, 0);
        chk("rst_stall", alloc_stall, 0);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_write", commit_write, 0);

        // Fill all 8 entries, then a stalled request.
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1'b1;
            chk("fill_alloc_id", alloc_id, i);
            chk("fill_stall", alloc_stall, 0);
            tick();
        end
        chk("full_stall", alloc_stall, 1);
        chk("full_occupancy", occupancy, 8);
        tick();
        chk("full_no_grant_occ", occupancy, 8);
        alloc_req = 1'b0;

        // Commit head while full with alloc_req held: no same-cycle bypass.
        set_wb(0, 0, 1, 'h100, 1'b1);
        push(0, 1, 'h100, 1);
        tick();
        clr();
        alloc_req = 1'b1;
        chk("bypass_stall", alloc_stall, 1);
        tick();
        chk("post_commit_stall", alloc_stall, 0);
        chk("wrap_alloc_id", alloc_id, 0);
        chk("post_commit_occ", occupancy, 7);
        tick();
        alloc_req = 1'b0;
        chk("refill_occ", occupancy, 8);

        for (int k = 1; k <= 8; k++) begin
            set_wb(0, k % 8, k, 'h200 + k, 1'b1);
            push(k % 8, k, 'h200 + k, 1);
            tick();
            clr();
        end
        drain("fill_drain");

        // Out-of-order completion retires in order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_req = 1'b1;
            chk("ooo_alloc_id", alloc_id, i);
            tick();
        end
        clr();
        push(0, 1, 'hA, 1);
        push(1, 2, 'hB, 1);
        push(2, 3, 'hC, 1);
        set_wb(1, 2, 3, 'hC, 1'b1);
        tick();
        clr();
        set_wb(0, 1, 2, 'hB, 1'b1);
        tick();
        clr();
        set_wb(0, 0, 1, 'hA, 1'b1);
        tick();
        clr();
        drain("ooo_drain");

        // Same-cycle writeback to ID 4 on both ports: port 0 wins.
        alloc_req = 1'b1;
        chk("dup_alloc_id3", alloc_id, 3);
        tick();
        chk("dup_alloc_id4", alloc_id, 4);
        tick();
        clr();
        push(3, 7, 'h33, 1);
        push(4, 5, 'h11, 1);
        set_wb(0, 4, 5, 'h11, 1'b1);
        set_wb(1, 4, 6, 'h22, 1'b1);
        tick();
        clr();
        set_wb(0, 3, 7, 'h33, 1'b1);
        tick();
        clr();
        drain("dup_drain");

        // Flush with a non-zero head.
        do_reset();
        alloc_req = 1'b1;
        tick();
        clr();
        set_wb(0, 0, 4, 'h44, 1'b1);
        push(0, 4, 'h44, 1);
        tick();
        clr();
        drain("pre_flush_drain");
        for (int i = 1; i <= 5; i++) begin
            alloc_req = 1'b1;
            chk("flush_alloc_id", alloc_id, i);
            tick();
        end
        clr();
        set_wb(0, 2, 2, 'h22, 1'b1);
        set_wb(1, 4, 4, 'h44, 1'b1);
        tick();
        clr();
        chk("pre_flush_occ", occupancy, 5);
        flush = 1'b1;
        alloc_req = 1'b1;
        set_wb(0, 1, 1, 'h11, 1'b1);
        tick();
        clr();
        chk("flush_occ", occupancy, 0);
        chk("flush_alloc_id_head", alloc_id, 1);
        chk("flush_stall", alloc_stall, 0);
        set_wb(0, 4, 4, 'h99, 1'b1);
        tick();
        clr();
        tick();
        chk("stale_wb_occ", occupancy, 0);
        alloc_req = 1'b1;
        chk("realloc_id", alloc_id, 1);
        tick();
        clr();
        set_wb(0, 1, 3, 'h77, 1'b1);
        push(1, 3, 'h77, 1);
        tick();
        clr();
        drain("flush_drain");

        // Write-disabled entry, then reset mid-operation.
        alloc_req = 1'b1;
        chk("now_alloc_id", alloc_id, 2);
        tick();
        clr();
        set_wb(1, 2, 9, 'h55, 1'b0);
        push(2, 9, 'h55, 0);
        tick();
        clr();
        drain("now_drain");
        for (int i = 0; i < 6; i++) begin
            alloc_req = 1'b1;
            tick();
        end
        clr();
        chk("mid_occ", occupancy, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_alloc_id", alloc_id, 0);
        chk("mid_rst_stall", alloc_stall, 0);
        chk("mid_rst_cvalid", commit_valid, 0);
        chk("mid_rst_cwrite", commit_write, 0);
        chk("mid_rst_cid", commit_id, 0);
        chk("mid_rst_caddr", commit_address, 0);
        chk("mid_rst_cdata", commit_data, 0);
        tick();
        tick();
        chk("final_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
